// File: rtl/sa_tile_os.sv
// sa_tile_os: N x N output-stationary systolic matmul tile (C = A*B).
// Job FSM, internal input skew, ready/valid row drain.
// Ports: start_i/k_len_i start a job; in_valid_i/in_ready_o with
// a_col_i/b_row_i carry operand beats; out_valid_o/out_ready_i with
// out_row_o/out_idx_o drain result rows; busy_o, done_o, ovf_o status.
// Build option: define SA_ACC_SAT_EN for saturating accumulators + ovf_o.
module sa_tile_os #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 48,
  parameter int KW         = 16
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               start_i,
  input  logic [KW-1:0]                      k_len_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic [N*DATA_WIDTH-1:0]            a_col_i,
  input  logic [N*DATA_WIDTH-1:0]            b_row_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [N*ACC_WIDTH-1:0]             out_row_o,
  output logic [((N>1)?$clog2(N):1)-1:0]     out_idx_o,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               ovf_o
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = ACC_WIDTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int FL = 2*N - 2;
  localparam int FW = $clog2(2*N) + 1;
  localparam logic [FW-1:0] FLAST = (FL == 0) ? '0 : FW'(FL - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [KW-1:0] klen_q, kcnt_q;
  logic [FW-1:0] fcnt_q;
  logic [IW-1:0] idx_q;
  logic          done_q;
  logic          clr, beat, step;
  logic          last_beat, flush_end;
  logic          row_hs, last_row;

  logic signed [DW-1:0] a_edge [N];
  logic signed [DW-1:0] b_edge [N];
  logic signed [DW-1:0] a_w [N][N];
  logic signed [DW-1:0] b_w [N][N];
  logic signed [AW-1:0] acc_w [N][N];

  assign clr       = (state_q == S_IDLE) && start_i;
  assign beat      = (state_q == S_LOAD) && in_valid_i;
  assign step      = beat || (state_q == S_FLUSH);
  assign last_beat = beat && (kcnt_q == klen_q - KW'(1));
  assign flush_end = (state_q == S_FLUSH) && (fcnt_q == FLAST);
  assign row_hs    = (state_q == S_DRAIN) && out_ready_i;
  assign last_row  = row_hs && (idx_q == IW'(N - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:
        if (start_i)
          state_d = (k_len_i == '0) ? S_FLUSH : S_LOAD;
      S_LOAD:
        if (last_beat)
          state_d = (N == 1) ? S_DRAIN : S_FLUSH;
      S_FLUSH:
        if (flush_end) state_d = S_DRAIN;
      S_DRAIN:
        if (last_row) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      klen_q  <= '0;
      kcnt_q  <= '0;
      fcnt_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= last_row;
      if (clr) klen_q <= k_len_i;
      if (clr) kcnt_q <= '0;
      else if (beat) kcnt_q <= kcnt_q + KW'(1);
      if (state_q != S_FLUSH) fcnt_q <= '0;
      else fcnt_q <= fcnt_q + FW'(1);
      if (clr) idx_q <= '0;
      else if (row_hs)
        idx_q <= last_row ? '0 : idx_q + IW'(1);
    end
  end

  // Edge skew: row i of A and column j of B see i / j step delays.
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic signed [DW-1:0] a_in, b_in;
    assign a_in = (state_q == S_LOAD) ? a_col_i[i*DW +: DW] : '0;
    assign b_in = (state_q == S_LOAD) ? b_row_i[i*DW +: DW] : '0;
    if (i == 0) begin : g_d0
      assign a_edge[i] = a_in;
      assign b_edge[i] = b_in;
    end else begin : g_dn
      logic signed [DW-1:0] sa_q [i];
      logic signed [DW-1:0] sb_q [i];
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int d = 0; d < i; d++) begin
            sa_q[d] <= '0;
            sb_q[d] <= '0;
          end
        end else if (clr) begin
          for (int d = 0; d < i; d++) begin
            sa_q[d] <= '0;
            sb_q[d] <= '0;
          end
        end else if (step) begin
          sa_q[0] <= a_in;
          sb_q[0] <= b_in;
          for (int d = 1; d < i; d++) begin
            sa_q[d] <= sa_q[d-1];
            sb_q[d] <= sb_q[d-1];
          end
        end
      end
      assign a_edge[i] = sa_q[i-1];
      assign b_edge[i] = sb_q[i-1];
    end
  end

`ifdef SA_ACC_SAT_EN
  logic [N*N-1:0] sat_w;
`endif

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_pe
      logic signed [DW-1:0]   a_x, b_x, ar_q, br_q;
      logic signed [2*DW-1:0] prod;
      logic signed [AW-1:0]   prod_x, acc_q, acc_d;
      if (j == 0) begin : g_ae
        assign a_x = a_edge[i];
      end else begin : g_af
        assign a_x = a_w[i][j-1];
      end
      if (i == 0) begin : g_be
        assign b_x = b_edge[j];
      end else begin : g_bf
        assign b_x = b_w[i-1][j];
      end
      assign prod   = a_x * b_x;
      assign prod_x = AW'(prod);
`ifdef SA_ACC_SAT_EN
      // One extra bit exposes signed overflow of the add.
      logic signed [AW:0] sum;
      logic               sat;
      assign sum = {acc_q[AW-1], acc_q} + {prod_x[AW-1], prod_x};
      always_comb begin
        sat   = 1'b0;
        acc_d = sum[AW-1:0];
        if (sum[AW] != sum[AW-1]) begin
          sat   = 1'b1;
          acc_d = sum[AW] ? {1'b1, {(AW-1){1'b0}}}
                          : {1'b0, {(AW-1){1'b1}}};
        end
      end
      assign sat_w[i*N+j] = sat && step;
`else
      assign acc_d = acc_q + prod_x;
`endif
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          ar_q  <= '0;
          br_q  <= '0;
          acc_q <= '0;
        end else if (clr) begin
          ar_q  <= '0;
          br_q  <= '0;
          acc_q <= '0;
        end else if (step) begin
          ar_q  <= a_x;
          br_q  <= b_x;
          acc_q <= acc_d;
        end
      end
      assign a_w[i][j]   = ar_q;
      assign b_w[i][j]   = br_q;
      assign acc_w[i][j] = acc_q;
    end
  end

`ifdef SA_ACC_SAT_EN
  logic ovf_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ovf_q <= 1'b0;
    else if (clr) ovf_q <= 1'b0;
    else if (|sat_w) ovf_q <= 1'b1;
  end
  assign ovf_o = ovf_q;
`else
  assign ovf_o = 1'b0;
`endif

  always_comb begin
    out_row_o = '0;
    if (state_q == S_DRAIN)
      for (int j = 0; j < N; j++)
        out_row_o[j*AW +: AW] = acc_w[idx_q][j];
  end

  assign in_ready_o  = (state_q == S_LOAD);
  assign out_valid_o = (state_q == S_DRAIN);
  assign out_idx_o   = idx_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;

endmodule

// File: tb/tb_sa_tile_os.sv
// tb_sa_tile_os: directed checks for sa_tile_os at N=4, N=2 (32-bit acc)
// and N=1; table vectors plus multi-cycle stall/reset sequences.
module tb_sa_tile_os;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;

  // N=4 instance
  logic         s4 = 0, iv4 = 0, or4 = 0;
  logic [15:0]  kl4 = 0;
  logic [63:0]  a4 = 0, b4 = 0;
  logic         ir4, ov4, busy4, done4, ovf4;
  logic [191:0] row4;
  logic [1:0]   idx4;

  sa_tile_os u4 (
    .clk(clk), .rstn(rstn), .start_i(s4), .k_len_i(kl4),
    .in_valid_i(iv4), .in_ready_o(ir4), .a_col_i(a4), .b_row_i(b4),
    .out_valid_o(ov4), .out_ready_i(or4), .out_row_o(row4),
    .out_idx_o(idx4), .busy_o(busy4), .done_o(done4), .ovf_o(ovf4)
  );

  // N=2, 32-bit accumulator instance
  logic        s2 = 0, iv2 = 0, or2 = 0;
  logic [15:0] kl2 = 0;
  logic [31:0] a2 = 0, b2 = 0;
  logic        ir2, ov2, busy2, done2, ovf2;
  logic [63:0] row2;
  logic [0:0]  idx2;

  sa_tile_os #(.N(2), .ACC_WIDTH(32)) u2 (
    .clk(clk), .rstn(rstn), .start_i(s2), .k_len_i(kl2),
    .in_valid_i(iv2), .in_ready_o(ir2), .a_col_i(a2), .b_row_i(b2),
    .out_valid_o(ov2), .out_ready_i(or2), .out_row_o(row2),
    .out_idx_o(idx2), .busy_o(busy2), .done_o(done2), .ovf_o(ovf2)
  );

  // N=1 instance
  logic        s1 = 0, iv1 = 0, or1 = 0;
  logic [15:0] kl1 = 0;
  logic [15:0] a1 = 0, b1 = 0;
  logic        ir1, ov1, busy1, done1, ovf1;
  logic [47:0] row1;
  logic [0:0]  idx1;

  sa_tile_os #(.N(1)) u1 (
    .clk(clk), .rstn(rstn), .start_i(s1), .k_len_i(kl1),
    .in_valid_i(iv1), .in_ready_o(ir1), .a_col_i(a1), .b_row_i(b1),
    .out_valid_o(ov1), .out_ready_i(or1), .out_row_o(row1),
    .out_idx_o(idx1), .busy_o(busy1), .done_o(done1), .ovf_o(ovf1)
  );

  typedef struct packed {
    logic [15:0]       k;
    logic [3:0][15:0]  a;
    logic [3:0][15:0]  b;
    logic [15:0][47:0] c;
    logic              stall;
    logic [1:0]        bp;
  } vec_t;

  vec_t        tbl [4];
  logic [63:0] am4 [8];
  logic [63:0] bm4 [8];
  longint      exp4 [16];
  logic [31:0] am2 [3];
  logic [31:0] bm2 [3];
  longint      exp2 [4];

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model4(input int k);
    longint s;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int kk = 0; kk < k; kk++)
          s += longint'($signed(am4[kk][i*16 +: 16])) *
               longint'($signed(bm4[kk][j*16 +: 16]));
        exp4[i*4+j] = s;
      end
  endtask

  task automatic chk_row4(input string nm, input int r);
    for (int j = 0; j < 4; j++)
      chk(nm, $signed(row4[j*48 +: 48]), exp4[r*4+j]);
    chk({nm, " idx"}, longint'(idx4), longint'(r));
  endtask

  task automatic run4(input int k, input bit stall, input int bp,
                      input string nm);
    int  beat, cyc;
    bit  v;
    s4 = 1; kl4 = 16'(k);
    tick;
    s4 = 0;
    chk({nm, " busy"}, longint'(busy4), 1);
    chk({nm, " in_ready"}, longint'(ir4), longint'(k > 0));
    beat = 0; cyc = 0;
    while (beat < k && cyc < 400) begin
      v = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      iv4 = v; a4 = am4[beat]; b4 = bm4[beat];
      if (v && ir4) beat++;
      tick;
      cyc++;
    end
    iv4 = 0;
    chk({nm, " beats"}, longint'(beat), longint'(k));
    cyc = 1;
    while (!ov4 && cyc < 50) begin
      tick;
      cyc++;
    end
    chk({nm, " out_valid"}, longint'(ov4), 1);
    if (!stall) chk({nm, " latency"}, longint'(cyc), 7);
    for (int r = 0; r < 4; r++) begin
      or4 = 0;
      for (int h = 0; h < bp; h++) begin
        chk_row4({nm, " hold"}, r);
        tick;
      end
      or4 = 1;
      chk_row4({nm, " row"}, r);
      tick;
    end
    or4 = 0;
    chk({nm, " done"}, longint'(done4), 1);
    chk({nm, " busy_end"}, longint'(busy4), 0);
    chk({nm, " ovf"}, longint'(ovf4), 0);
    tick;
    chk({nm, " done_pulse"}, longint'(done4), 0);
  endtask

  task automatic run2(input int k, input string nm, input bit eovf);
    int cyc;
    s2 = 1; kl2 = 16'(k);
    tick;
    s2 = 0;
    for (int b = 0; b < k; b++) begin
      iv2 = 1; a2 = am2[b]; b2 = bm2[b];
      chk({nm, " in_ready"}, longint'(ir2), 1);
      tick;
    end
    iv2 = 0;
    cyc = 1;
    while (!ov2 && cyc < 20) begin
      tick;
      cyc++;
    end
    chk({nm, " latency"}, longint'(cyc), 3);
    for (int r = 0; r < 2; r++) begin
      or2 = 1;
      chk({nm, " idx"}, longint'(idx2), longint'(r));
      for (int j = 0; j < 2; j++)
        chk({nm, " row"}, $signed(row2[j*32 +: 32]), exp2[r*2+j]);
      tick;
    end
    or2 = 0;
    chk({nm, " done"}, longint'(done2), 1);
    chk({nm, " busy_end"}, longint'(busy2), 0);
    chk({nm, " ovf"}, longint'(ovf2), longint'(eovf));
    tick;
    chk({nm, " done_pulse"}, longint'(done2), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Table: N=4 vectors with hand-computed C
    tbl[0].k = 16'd1;
    tbl[0].a = {16'h8000, 16'sd2, -16'sd1, -16'sd3};
    tbl[0].b = {16'sd7, -16'sd1, 16'sd1, 16'h8000};
    tbl[0].c = {-48'sd229376, 48'sd32768, -48'sd32768, 48'sd1073741824,
                48'sd14, -48'sd2, 48'sd2, -48'sd65536,
                -48'sd7, 48'sd1, -48'sd1, 48'sd32768,
                -48'sd21, 48'sd3, -48'sd3, 48'sd98304};
    tbl[0].stall = 1'b0;
    tbl[0].bp = 2'd0;
    tbl[1] = tbl[0];
    tbl[1].stall = 1'b1;
    tbl[1].bp = 2'd2;
    tbl[2] = tbl[0];
    tbl[2].k = 16'd0;
    tbl[2].c = '0;
    tbl[3].k = 16'd1;
    tbl[3].a = {16'sd4, 16'sd3, 16'sd2, 16'sd1};
    tbl[3].b = {16'sd100, -16'sd1, 16'sd0, 16'sd1};
    tbl[3].c = {48'sd400, -48'sd4, 48'sd0, 48'sd4,
                48'sd300, -48'sd3, 48'sd0, 48'sd3,
                48'sd200, -48'sd2, 48'sd0, 48'sd2,
                48'sd100, -48'sd1, 48'sd0, 48'sd1};
    tbl[3].stall = 1'b0;
    tbl[3].bp = 2'd1;

    #12;
    chk("rst in_ready", longint'(ir4), 0);
    chk("rst out_valid", longint'(ov4), 0);
    chk("rst out_row", longint'(|row4), 0);
    chk("rst out_idx", longint'(idx4), 0);
    chk("rst busy", longint'(busy4), 0);
    chk("rst done", longint'(done4), 0);
    chk("rst ovf", longint'(ovf4), 0);
    tick;
    rstn = 1;
    tick;

    for (int t = 0; t < 4; t++) begin
      am4[0] = tbl[t].a;
      bm4[0] = tbl[t].b;
      for (int e = 0; e < 16; e++) exp4[e] = $signed(tbl[t].c[e]);
      run4(int'(tbl[t].k), tbl[t].stall, int'(tbl[t].bp),
           $sformatf("vec%0d", t));
    end

    // Random K=8 with stalls and 3-cycle back-pressure per row
    for (int b = 0; b < 8; b++) begin
      am4[b] = {$urandom, $urandom};
      bm4[b] = {$urandom, $urandom};
    end
    model4(8);
    run4(8, 1'b1, 3, "rand");

    // Basic 2x2
    am2[0] = {16'sd3, 16'sd1}; am2[1] = {16'sd4, 16'sd2};
    bm2[0] = {16'sd6, 16'sd5}; bm2[1] = {16'sd8, 16'sd7};
    exp2[0] = 19; exp2[1] = 22; exp2[2] = 43; exp2[3] = 50;
    run2(2, "basic2", 1'b0);

    // Overflow, 32-bit accumulators
    for (int b = 0; b < 3; b++) begin
      am2[b] = 32'h8000_8000;
      bm2[b] = 32'h8000_8000;
    end
`ifdef SA_ACC_SAT_EN
    for (int e = 0; e < 4; e++) exp2[e] = 2147483647;
    run2(3, "ovf", 1'b1);
`else
    for (int e = 0; e < 4; e++) exp2[e] = -1073741824;
    run2(3, "ovf", 1'b0);
`endif

    // N=1, K=3
    s1 = 1; kl1 = 16'd3;
    tick;
    s1 = 0; iv1 = 1;
    a1 = 16'sd2; b1 = 16'sd5; tick;
    a1 = 16'sd3; b1 = 16'sd6; tick;
    a1 = 16'sd4; b1 = 16'sd7; tick;
    iv1 = 0;
    chk("n1 out_valid", longint'(ov1), 1);
    chk("n1 idx", longint'(idx1), 0);
    chk("n1 row", $signed(row1), 56);
    or1 = 1;
    tick;
    or1 = 0;
    chk("n1 done", longint'(done1), 1);
    chk("n1 busy", longint'(busy1), 0);

    // Reset during beat 3 of a K=8 job
    for (int b = 0; b < 8; b++) begin
      am4[b] = {$urandom, $urandom};
      bm4[b] = {$urandom, $urandom};
    end
    s4 = 1; kl4 = 16'd8;
    tick;
    s4 = 0; iv4 = 1;
    for (int b = 0; b < 3; b++) begin
      a4 = am4[b]; b4 = bm4[b];
      tick;
    end
    a4 = am4[3]; b4 = bm4[3];
    #2;
    rstn = 0;
    #1;
    chk("mid in_ready", longint'(ir4), 0);
    chk("mid out_valid", longint'(ov4), 0);
    chk("mid out_row", longint'(|row4), 0);
    chk("mid out_idx", longint'(idx4), 0);
    chk("mid busy", longint'(busy4), 0);
    chk("mid done", longint'(done4), 0);
    chk("mid ovf", longint'(ovf4), 0);
    tick;
    tick;
    iv4 = 0;
    rstn = 1;
    tick;
    for (int b = 0; b < 2; b++) begin
      am4[b] = {$urandom, $urandom};
      bm4[b] = {$urandom, $urandom};
    end
    model4(2);
    run4(2, 1'b0, 0, "post_rst");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
